// File: rtl/tl45_bus_pkg.sv
// Shared bus-arbitration types for the TL45 Wishbone fabric: arbiter FSM
// states and the owner encodings reported on o_grant.
package tl45_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN_A = 2'b01,
        ST_OWN_B = 2'b10,
        ST_ABORT = 2'b11
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_A    = 2'b01;
    localparam logic [1:0] GRANT_B    = 2'b10;

    localparam int OUTST_W = 5;

endpackage

// File: rtl/tl45_wb_watchdog.sv
// Bus watchdog: counts stalled-response cycles while requests are outstanding
// and flags the cycle in which the count reaches TIMEOUT.
module tl45_wb_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_active,
    input  logic i_resp,
    output logic o_timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic             count_s;

    // The current waiting cycle is included, so the pulse lands on the
    // TIMEOUT-th consecutive cycle without a response.
    assign count_s   = i_active && !i_resp;
    assign o_timeout = count_s && (cnt_r == CNT_LAST);

    // Wait-cycle counter, cleared by any response or idle cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (count_s && (cnt_r != CNT_LAST)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

endmodule

// File: rtl/tl45_wb_arbiter.sv
// Two-master Wishbone arbiter: B (data stage) has priority, A (fetch) is
// protected from starvation, and a watchdog aborts hung transfers.
module tl45_wb_arbiter
    import tl45_bus_pkg::*;
#(
    parameter int TIMEOUT      = 1023,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_a_cyc,
    input  logic        i_a_stb,
    input  logic        i_a_we,
    input  logic [29:0] i_a_addr,
    input  logic [31:0] i_a_data,
    input  logic [3:0]  i_a_sel,
    output logic        o_a_ack,
    output logic        o_a_stall,
    output logic        o_a_err,
    input  logic        i_b_cyc,
    input  logic        i_b_stb,
    input  logic        i_b_we,
    input  logic [29:0] i_b_addr,
    input  logic [31:0] i_b_data,
    input  logic [3:0]  i_b_sel,
    output logic        o_b_ack,
    output logic        o_b_stall,
    output logic        o_b_err,
    output logic [31:0] o_ab_data,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [29:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);
    localparam logic [OUTST_W-1:0]  OUTST_ONE  = OUTST_W'(1);

    arb_state_t          state_r;
    logic [1:0]          grant_r;
    logic [STARVE_W-1:0] starve_r;
    logic [OUTST_W-1:0]  outstanding_r;

    logic wd_timeout_s;
    logic wd_active_s;
    logic resp_s;
    logic inc_s;
    logic dec_s;
    logic stay_own_s;
    logic owner_cyc_s;
    logic a_starved_s;

    assign o_grant     = grant_r;
    assign o_ab_data   = i_wb_data;
    assign o_timeout   = wd_timeout_s;
    assign resp_s      = i_wb_ack || i_wb_err;
    assign inc_s       = o_wb_stb && !i_wb_stall;
    assign dec_s       = resp_s;
    assign owner_cyc_s = (grant_r == GRANT_B) ? i_b_cyc : i_a_cyc;
    assign a_starved_s = i_a_cyc && (starve_r == STARVE_MAX);
    assign wd_active_s = ((state_r == ST_OWN_A) || (state_r == ST_OWN_B))
                         && (outstanding_r != {OUTST_W{1'b0}});
    // Leaving ownership (cyc drop or abort) wipes the outstanding count.
    assign stay_own_s  = ((state_r == ST_OWN_A) && i_a_cyc && !wd_timeout_s)
                         || ((state_r == ST_OWN_B) && i_b_cyc && !wd_timeout_s);

    tl45_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_active  (wd_active_s),
        .i_resp    (resp_s),
        .o_timeout (wd_timeout_s)
    );

    // Slave-side mux and master response routing from the current owner.
    always_comb begin
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_addr = 30'h0;
        o_wb_data = 32'h0;
        o_wb_sel  = 4'h0;
        o_a_stall = 1'b1;
        o_a_ack   = 1'b0;
        o_a_err   = 1'b0;
        o_b_stall = 1'b1;
        o_b_ack   = 1'b0;
        o_b_err   = 1'b0;
        case (state_r)
            ST_OWN_A: begin
                o_wb_cyc  = i_a_cyc;
                o_wb_stb  = i_a_stb;
                o_wb_we   = i_a_we;
                o_wb_addr = i_a_addr;
                o_wb_data = i_a_data;
                o_wb_sel  = i_a_sel;
                o_a_stall = i_wb_stall;
                o_a_ack   = i_wb_ack;
                o_a_err   = i_wb_err || wd_timeout_s;
            end
            ST_OWN_B: begin
                o_wb_cyc  = i_b_cyc;
                o_wb_stb  = i_b_stb;
                o_wb_we   = i_b_we;
                o_wb_addr = i_b_addr;
                o_wb_data = i_b_data;
                o_wb_sel  = i_b_sel;
                o_b_stall = i_wb_stall;
                o_b_ack   = i_wb_ack;
                o_b_err   = i_wb_err || wd_timeout_s;
            end
            ST_IDLE:  o_wb_cyc = 1'b0;
            ST_ABORT: o_wb_cyc = 1'b0;
            default:  o_wb_cyc = 1'b0;
        endcase
    end

    // Ownership FSM with starvation counter and registered grant.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r  <= ST_IDLE;
            grant_r  <= GRANT_NONE;
            starve_r <= {STARVE_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_b_cyc && !a_starved_s) begin
                        state_r <= ST_OWN_B;
                        grant_r <= GRANT_B;
                        if (i_a_cyc && (starve_r != STARVE_MAX)) begin
                            starve_r <= starve_r + STARVE_ONE;
                        end
                    end else if (i_a_cyc) begin
                        state_r  <= ST_OWN_A;
                        grant_r  <= GRANT_A;
                        starve_r <= {STARVE_W{1'b0}};
                    end
                end
                ST_OWN_A, ST_OWN_B: begin
                    if (wd_timeout_s) begin
                        state_r <= ST_ABORT;
                    end else if (!owner_cyc_s) begin
                        state_r <= ST_IDLE;
                        grant_r <= GRANT_NONE;
                    end
                end
                ST_ABORT: begin
                    if (!owner_cyc_s) begin
                        state_r <= ST_IDLE;
                        grant_r <= GRANT_NONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= GRANT_NONE;
                end
            endcase
        end
    end

    // Outstanding-request counter; simultaneous accept and response cancel.
    always_ff @(posedge i_clk) begin
        if (i_reset || !stay_own_s) begin
            outstanding_r <= {OUTST_W{1'b0}};
        end else if (inc_s && !dec_s) begin
            outstanding_r <= outstanding_r + OUTST_ONE;
        end else if (dec_s && !inc_s && (outstanding_r != {OUTST_W{1'b0}})) begin
            outstanding_r <= outstanding_r - OUTST_ONE;
        end else begin
            outstanding_r <= outstanding_r;
        end
    end

endmodule

// File: tb/tb_tl45_wb_arbiter.sv
// Self-checking bench for tl45_wb_arbiter: arbitration vector table plus
// hand-written burst, timeout, reset and abort sequences.
module tb_tl45_wb_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_a_cyc, i_a_stb, i_a_we;
    logic [29:0] i_a_addr;
    logic [31:0] i_a_data;
    logic [3:0]  i_a_sel;
    logic        o_a_ack, o_a_stall, o_a_err;
    logic        i_b_cyc, i_b_stb, i_b_we;
    logic [29:0] i_b_addr;
    logic [31:0] i_b_data;
    logic [3:0]  i_b_sel;
    logic        o_b_ack, o_b_stall, o_b_err;
    logic [31:0] o_ab_data;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [29:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_ack, i_wb_stall, i_wb_err;
    logic [31:0] i_wb_data;
    logic [1:0]  o_grant;
    logic        o_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       a_cyc;
        logic       b_cyc;
        logic       wb_stall;
        logic [1:0] grant;
        logic       wb_cyc;
        logic       a_stall;
        logic       b_stall;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];

    always #5 i_clk = ~i_clk;

    tl45_wb_arbiter #(
        .TIMEOUT      (8),
        .STARVE_LIMIT (4)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_a_cyc    (i_a_cyc),
        .i_a_stb    (i_a_stb),
        .i_a_we     (i_a_we),
        .i_a_addr   (i_a_addr),
        .i_a_data   (i_a_data),
        .i_a_sel    (i_a_sel),
        .o_a_ack    (o_a_ack),
        .o_a_stall  (o_a_stall),
        .o_a_err    (o_a_err),
        .i_b_cyc    (i_b_cyc),
        .i_b_stb    (i_b_stb),
        .i_b_we     (i_b_we),
        .i_b_addr   (i_b_addr),
        .i_b_data   (i_b_data),
        .i_b_sel    (i_b_sel),
        .o_b_ack    (o_b_ack),
        .o_b_stall  (o_b_stall),
        .o_b_err    (o_b_err),
        .o_ab_data  (o_ab_data),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .o_wb_sel   (o_wb_sel),
        .i_wb_ack   (i_wb_ack),
        .i_wb_stall (i_wb_stall),
        .i_wb_err   (i_wb_err),
        .i_wb_data  (i_wb_data),
        .o_grant    (o_grant),
        .o_timeout  (o_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic add_vec(input logic a, input logic b, input logic st, input logic [1:0] g,
                           input logic wc, input logic as, input logic bs);
        vec_t v;
        v = '{a_cyc: a, b_cyc: b, wb_stall: st, grant: g, wb_cyc: wc, a_stall: as, b_stall: bs};
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] rd_data(input logic [29:0] addr);
        return {addr[27:0], 4'h5} ^ 32'hA5C3_0000;
    endfunction

    initial begin
        logic [29:0] pend_addr;
        logic        pend_v;
        int          issued;
        int          acked;

        i_reset = 1'b1;
        {i_a_cyc, i_a_stb, i_a_we, i_b_cyc, i_b_stb, i_b_we} = 6'b0;
        i_a_addr = 30'h0; i_a_data = 32'h1111_0000; i_a_sel = 4'hF;
        i_b_addr = 30'h0; i_b_data = 32'h2222_0000; i_b_sel = 4'h3;
        {i_wb_ack, i_wb_stall, i_wb_err} = 3'b0;
        i_wb_data = 32'h0;

        // reset state
        tick();
        tick();
        @(negedge i_clk);
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_wb_cyc", 32'(o_wb_cyc), 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        chk("rst_a_stall", 32'(o_a_stall), 32'd1);
        chk("rst_b_stall", 32'(o_b_stall), 32'd1);
        tick();
        i_reset = 1'b0;

        // a, b, wb_stall -> grant, wb_cyc, a_stall, b_stall
        add_vec(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        add_vec(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        add_vec(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1);
        add_vec(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        add_vec(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1);
        add_vec(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
        add_vec(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        for (int g = 0; g < 4; g++) begin
            add_vec(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
            add_vec(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0);
        end
        add_vec(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        add_vec(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1);
        add_vec(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
        add_vec(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        add_vec(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);

        foreach (vecs[i]) begin
            i_a_cyc    = vecs[i].a_cyc;
            i_b_cyc    = vecs[i].b_cyc;
            i_wb_stall = vecs[i].wb_stall;
            @(negedge i_clk);
            chk($sformatf("vec%0d_grant", i), 32'(o_grant), 32'(vecs[i].grant));
            chk($sformatf("vec%0d_wb_cyc", i), 32'(o_wb_cyc), 32'(vecs[i].wb_cyc));
            chk($sformatf("vec%0d_a_stall", i), 32'(o_a_stall), 32'(vecs[i].a_stall));
            chk($sformatf("vec%0d_b_stall", i), 32'(o_b_stall), 32'(vecs[i].b_stall));
            tick();
        end

        // 16-beat burst from A with a stalling slave answering one cycle later
        i_a_cyc = 1'b1;
        i_wb_stall = 1'b0;
        tick();
        issued = 0;
        acked  = 0;
        pend_v = 1'b0;
        pend_addr = 30'h0;
        for (int k = 0; k < 80 && acked < 16; k++) begin
            i_a_stb    = (issued < 16);
            i_a_addr   = 30'h100 + 30'(issued);
            i_wb_stall = ((k % 3) == 1);
            i_wb_ack   = pend_v;
            i_wb_data  = pend_v ? rd_data(pend_addr) : 32'h0;
            @(negedge i_clk);
            chk("burst_grant", 32'(o_grant), 32'd1);
            chk("burst_b_stall", 32'(o_b_stall), 32'd1);
            chk("burst_b_ack", 32'(o_b_ack), 32'd0);
            chk("burst_a_ack", 32'(o_a_ack), 32'(pend_v));
            if (o_a_ack) begin
                if (sb.size() == 0) begin
                    chk("burst_sb_empty", 32'd0, 32'd1);
                end else begin
                    chk("burst_data", o_ab_data, sb.pop_front());
                end
                acked++;
            end
            if (i_a_stb && !i_wb_stall) begin
                chk("burst_addr", 32'(o_wb_addr), 32'(30'h100 + 30'(issued)));
                sb.push_back(rd_data(i_a_addr));
                pend_addr = i_a_addr;
                pend_v = 1'b1;
                issued++;
            end else begin
                pend_v = 1'b0;
            end
            tick();
        end
        i_a_stb = 1'b0;
        i_wb_ack = 1'b0;
        i_wb_stall = 1'b0;
        @(negedge i_clk);
        chk("burst_ack_count", 32'(acked), 32'd16);
        chk("burst_sb_left", 32'(sb.size()), 32'd0);
        chk("burst_outstanding", 32'(dut.outstanding_r), 32'd0);
        tick();
        i_a_cyc = 1'b0;
        tick();

        // slave never answers: watchdog abort with TIMEOUT=8
        i_a_cyc = 1'b1;
        tick();
        i_a_stb = 1'b1;
        @(negedge i_clk);
        chk("to_grant", 32'(o_grant), 32'd1);
        tick();
        i_a_stb = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge i_clk);
            chk($sformatf("to_early%0d", k), 32'({o_timeout, o_a_err}), 32'd0);
            tick();
        end
        @(negedge i_clk);
        chk("to_pulse", 32'(o_timeout), 32'd1);
        chk("to_a_err", 32'(o_a_err), 32'd1);
        tick();
        i_wb_ack = 1'b1;
        @(negedge i_clk);
        chk("abort_wb_cyc", 32'(o_wb_cyc), 32'd0);
        chk("abort_grant", 32'(o_grant), 32'd1);
        chk("abort_ack_drop", 32'(o_a_ack), 32'd0);
        chk("abort_stall", 32'(o_a_stall), 32'd1);
        chk("abort_pulse_end", 32'(o_timeout), 32'd0);
        tick();
        i_wb_ack = 1'b0;
        i_a_cyc = 1'b0;
        @(negedge i_clk);
        chk("abort_hold", 32'(o_grant), 32'd1);
        tick();
        @(negedge i_clk);
        chk("abort_exit", 32'(o_grant), 32'd0);
        tick();

        // reset in the middle of a B burst
        i_b_cyc = 1'b1;
        tick();
        i_b_stb = 1'b1;
        tick();
        i_reset = 1'b1;
        @(negedge i_clk);
        chk("rstb_pre_wb_cyc", 32'(o_wb_cyc), 32'd1);
        tick();
        i_reset = 1'b0;
        i_b_stb = 1'b0;
        i_wb_ack = 1'b1;
        @(negedge i_clk);
        chk("rstb_wb_cyc", 32'(o_wb_cyc), 32'd0);
        chk("rstb_grant", 32'(o_grant), 32'd0);
        chk("rstb_late_ack", 32'(o_b_ack), 32'd0);
        chk("rstb_outstanding", 32'(dut.outstanding_r), 32'd0);
        tick();
        i_wb_ack = 1'b0;
        i_b_cyc = 1'b0;
        @(negedge i_clk);
        chk("rstb_regrant", 32'(o_grant), 32'd2);
        tick();
        tick();

        // owner drops cyc with two requests outstanding
        i_a_cyc = 1'b1;
        tick();
        i_a_stb = 1'b1;
        tick();
        tick();
        i_a_cyc = 1'b0;
        i_a_stb = 1'b0;
        @(negedge i_clk);
        chk("drop_outstanding", 32'(dut.outstanding_r), 32'd2);
        chk("drop_grant", 32'(o_grant), 32'd1);
        tick();
        i_wb_ack = 1'b1;
        @(negedge i_clk);
        chk("drop_idle", 32'(o_grant), 32'd0);
        chk("drop_cleared", 32'(dut.outstanding_r), 32'd0);
        chk("drop_stray_ack", 32'({o_a_ack, o_b_ack}), 32'd0);
        tick();
        i_wb_ack = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tl45_wb_arbiter.md
TL45_WB_ARBITER -- requirements
Module: tl45_wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, which sets the number of cycles of no-ack with outstanding requests before an abort.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, which sets the maximum number of consecutive B grants while A waits.
REQ-003 SHALL provide the following ports (name, direction, width, meaning), clock and reset first:
- i_clk  in  1  clock.
- i_reset  in  1  reset; synchronous, active-high.
- i_a_cyc, i_a_stb, i_a_we  in  1 each  master A (instruction fetch/cache refill) request.
- i_a_addr / i_a_data / i_a_sel  in  30/32/4  master A address, write data, byte select.
- o_a_ack, o_a_stall, o_a_err  out  1 each  master A response.
- i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data, i_b_sel  in  1/1/1/30/32/4  master B (data memory stage), same meanings as A.
- o_b_ack, o_b_stall, o_b_err  out  1 each  master B response.
- o_ab_data  out  32  i_wb_data broadcast to both masters.
- o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel  out  1/1/1/30/32/4  slave-side bus.
- i_wb_ack, i_wb_stall, i_wb_err, i_wb_data  in  1/1/1/32  slave response.
- o_grant  out  2  owner: 00 none, 01 A, 10 B.
- o_timeout  out  1  one-cycle pulse on watchdog abort.

Function
REQ-004 SHALL implement a registered FSM with states IDLE, OWN_A, OWN_B, ABORT.
REQ-005 IDLE: o_wb_cyc=0, o_wb_stb=0; both o_x_stall=1; acks/errs=0.
REQ-006 IDLE with i_b_cyc SHALL go to OWN_B, except when i_a_cyc is high and the starve count equals STARVE_LIMIT, in which case it SHALL go to OWN_A; i_a_cyc alone SHALL go to OWN_A; grant latency is 1 cycle.
REQ-007 Starve count SHALL increment on each B grant made while i_a_cyc is high, clear on each A grant, and saturate at STARVE_LIMIT.
REQ-008 In OWN_x, slave outputs SHALL be a combinational mux of master x: o_wb_cyc=i_x_cyc, o_wb_stb=i_x_stb, plus we/addr/data/sel.
REQ-009 In OWN_x, the owner SHALL receive o_x_stall=i_wb_stall, o_x_ack=i_wb_ack, o_x_err=i_wb_err; the non-owner SHALL receive stall=1, ack=0, err=0.
REQ-010 An outstanding counter (5 bits) SHALL do +1 on o_wb_stb&&!i_wb_stall and -1 on i_wb_ack||i_wb_err, with both events in one cycle giving a net change of 0; it SHALL clear on entry to IDLE.
REQ-011 The owner deasserting i_x_cyc SHALL return the FSM to IDLE the next cycle regardless of outstanding count (Wishbone abort); the other master is arbitered from IDLE, so there is one dead cycle between owners.
REQ-012 The watchdog counter SHALL count cycles in OWN_x with outstanding>0 and no ack/err, and clear otherwise.
REQ-013 When the watchdog counter reaches TIMEOUT: the owner SHALL get o_x_err=1 for that cycle, o_timeout SHALL pulse, and the FSM SHALL enter ABORT.
REQ-014 ABORT: o_wb_cyc=0; the owner SHALL get stall=1, ack=0, err=0; the FSM SHALL stay in ABORT until the owner's i_x_cyc=0, then go to IDLE.
REQ-015 Slave ack/err arriving in ABORT or IDLE SHALL be dropped.
REQ-016 o_grant SHALL reflect the FSM state (ABORT reports the aborted owner).

Reset
REQ-017 i_reset SHALL force, on the next edge: FSM=IDLE, counters=0, starve count=0, o_timeout=0; hence o_wb_cyc=0 and o_grant=00, including mid-transfer.
REQ-018 Master requests present during reset SHALL be arbitered starting the cycle after reset deasserts.

Structure
REQ-019 The FSM state enum and the o_grant encodings SHALL live in the shared package tl45_bus_pkg.
REQ-020 The watchdog SHALL be a sub-module, tl45_wb_watchdog (counter, TIMEOUT compare, pulse out); arbitration SHALL stay in the top module.

Verification
REQ-021 The bench SHALL cover A and B raising cyc in the same cycle -> o_grant=10 one cycle later; A is granted after B's cyc drops plus the dead cycle.
REQ-022 The bench SHALL cover B re-requesting continuously for 5 cycles-of-ownership while A waits -> the 5th grant goes to A (STARVE_LIMIT=4).
REQ-023 The bench SHALL cover A doing a 16-beat burst with i_wb_stall toggling -> 16 acks routed to A, o_b_stall=1 throughout, outstanding returns to 0.
REQ-024 The bench SHALL cover the slave never acking, TIMEOUT=8 -> o_a_err and o_timeout high 8 cycles after the first accepted stb, o_wb_cyc=0 the next cycle, ABORT until i_a_cyc=0.
REQ-025 The bench SHALL cover i_reset asserted during an OWN_B burst -> o_wb_cyc=0 and o_grant=00 the next cycle; a late i_wb_ack is not forwarded.
REQ-026 The bench SHALL cover the owner dropping cyc with 2 outstanding -> IDLE next cycle, outstanding=0; a subsequent stray ack is ignored.
